msx_wait_gen: RTL

- Parametrised Z80 wait-state generator for the MSX core.
- Replaces the fixed single-M1-wait flop pair with independently counted wait states per bus-cycle type: opcode fetch, I/O and memory.
- Adds an external cartridge/slot wait input and a runtime enable for turbo operation.
- Sits between the T80 bus strobes and the CPU WAIT_n input; all timing is in ce_3m58_p ticks.

---
 rtl/msx_wait_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/msx_wait_gen.sv
// Z80 wait-state generator for the MSX core: counts per-cycle-type wait states
// (opcode fetch, I/O, memory) in CPU T-states and merges the slot wait request.
module msx_wait_gen #(
   parameter int M1_WAITS  = 1,
   parameter int IO_WAITS  = 0,
   parameter int MEM_WAITS = 0,
   parameter int CNT_W     = 4
) (
   input  logic       clk21m,
   input  logic       reset,
   input  logic       ce_3m58_p,
   input  logic       m1_n,
   input  logic       mreq_n,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       rfrsh_n,
   input  logic       exwait_n,
   input  logic       wait_en,
   output logic       wait_n,
   output logic [1:0] cyc_type
);

   localparam int MAX_WAITS = (1 << CNT_W) - 1;

   if (M1_WAITS < 0 || M1_WAITS > MAX_WAITS) begin : g_m1_range
      $error("M1_WAITS does not fit in CNT_W bits");
   end
   if (IO_WAITS < 0 || IO_WAITS > MAX_WAITS) begin : g_io_range
      $error("IO_WAITS does not fit in CNT_W bits");
   end
   if (MEM_WAITS < 0 || MEM_WAITS > MAX_WAITS) begin : g_mem_range
      $error("MEM_WAITS does not fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] M1_N  = CNT_W'(M1_WAITS);
   localparam logic [CNT_W-1:0] IO_N  = CNT_W'(IO_WAITS);
   localparam logic [CNT_W-1:0] MEM_N = CNT_W'(MEM_WAITS);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   localparam logic [1:0] CYC_NONE = 2'd0;
   localparam logic [1:0] CYC_M1   = 2'd1;
   localparam logic [1:0] CYC_IO   = 2'd2;
   localparam logic [1:0] CYC_MEM  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wait_n_q, wait_n_d;
   logic [1:0]       cyc_type_q, cyc_type_d;

   logic             class_hit;
   logic [1:0]       class_type;
   logic [CNT_W-1:0] class_waits;
   logic [CNT_W-1:0] load_n;
   logic             cyc_active;

   // First matching rule wins; refresh-only cycles fall through unclassified.
   always_comb begin
      class_hit   = 1'b0;
      class_type  = CYC_NONE;
      class_waits = '0;
      if (!m1_n && !mreq_n) begin
         class_hit   = 1'b1;
         class_type  = CYC_M1;
         class_waits = M1_N;
      end else if (!m1_n && !iorq_n) begin
         class_hit   = 1'b1;
         class_type  = CYC_NONE;
         class_waits = '0;
      end else if (m1_n && !iorq_n && (!rd_n || !wr_n)) begin
         class_hit   = 1'b1;
         class_type  = CYC_IO;
         class_waits = IO_N;
      end else if (m1_n && !mreq_n && rfrsh_n && (!rd_n || !wr_n)) begin
         class_hit   = 1'b1;
         class_type  = CYC_MEM;
         class_waits = MEM_N;
      end
   end

   assign load_n     = wait_en ? class_waits : '0;
   assign cyc_active = !mreq_n || !iorq_n;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wait_n_d   = wait_n_q;
      cyc_type_d = cyc_type_q;
      if (ce_3m58_p) begin
         case (state_q)
            ST_IDLE: begin
               if (class_hit) begin
                  cyc_type_d = class_type;
                  if (load_n != '0) begin
                     state_d  = ST_COUNT;
                     wait_n_d = 1'b0;
                     cnt_d    = load_n;
                  end else if (!exwait_n) begin
                     state_d  = ST_HOLD;
                     wait_n_d = 1'b0;
                  end else begin
                     state_d  = ST_DONE;
                     wait_n_d = 1'b1;
                  end
               end
            end
            ST_COUNT: begin
               if (!cyc_active) begin
                  state_d  = ST_IDLE;
                  wait_n_d = 1'b1;
                  cnt_d    = '0;
               end else if (cnt_q <= ONE) begin
                  // Last counted wait: hand over to the slot wait if it is still asserted.
                  cnt_d = '0;
                  if (!exwait_n) begin
                     state_d  = ST_HOLD;
                     wait_n_d = 1'b0;
                  end else begin
                     state_d  = ST_DONE;
                     wait_n_d = 1'b1;
                  end
               end else begin
                  cnt_d    = cnt_q - ONE;
                  wait_n_d = 1'b0;
               end
            end
            ST_HOLD: begin
               if (!cyc_active) begin
                  state_d  = ST_IDLE;
                  wait_n_d = 1'b1;
               end else if (exwait_n) begin
                  state_d  = ST_DONE;
                  wait_n_d = 1'b1;
               end else begin
                  wait_n_d = 1'b0;
               end
            end
            ST_DONE: begin
               wait_n_d = 1'b1;
               // Stay here until the bus cycle ends so one cycle never retriggers.
               if (mreq_n && iorq_n) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               wait_n_d = 1'b1;
               cnt_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         wait_n_q   <= 1'b1;
         cyc_type_q <= CYC_NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wait_n_q   <= wait_n_d;
         cyc_type_q <= cyc_type_d;
      end
   end

   assign wait_n   = wait_n_q;
   assign cyc_type = cyc_type_q;

endmodule
